// File: rtl/biquad_pkg.sv
// biquad_pkg: shared coefficient layout and loader state encoding for the biquad filter
package biquad_pkg;
  localparam int COEFS_PER_SECTION = 5;
  localparam int COEF_W = 16;
  localparam int BRAM_ADR_W = 11;
  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;
  typedef enum logic [1:0] {IDLE, READ, COMMIT_WAIT} state_e;
endpackage

// File: rtl/biquad_coef_loader.sv
// biquad_coef_loader: reads a full coefficient set from BRAM into a shadow bank and commits it atomically
module biquad_coef_loader
  import biquad_pkg::*;
#(
  parameter int NUM_SECTIONS = 4,
  parameter logic [BRAM_ADR_W-1:0] BASE_ADR = 11'h000,
  parameter bit COMMIT_ON_STROBE = 1'b1
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic load_new_coefficients,
  output logic done_loading,
  input  logic sample_strobe_i,
  output logic cbram_wb_cyc_o,
  output logic cbram_wb_stb_o,
  output logic cbram_wb_we_o,
  output logic [BRAM_ADR_W-1:0] cbram_wb_adr_o,
  input  logic [COEF_W-1:0] cbram_wb_dat_i,
  input  logic cbram_wb_ack_i,
  output logic [NUM_SECTIONS*COEFS_PER_SECTION*COEF_W-1:0] coef_o,
  output logic coef_valid_o
);
  localparam int N = NUM_SECTIONS * COEFS_PER_SECTION;
  localparam int IW = $clog2(N + 1);
  localparam int W = N * COEF_W;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic valid_q, valid_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: if (load_new_coefficients) begin
        idx_d = '0;
        state_d = READ;
      end
      READ: if (cbram_wb_ack_i) begin
        shadow_d[COEF_W*idx_q +: COEF_W] = cbram_wb_dat_i;
        idx_d = idx_q + IW'(1);
        state_d = (idx_q == IW'(N - 1)) ? COMMIT_WAIT : READ;
      end
      COMMIT_WAIT: if (!COMMIT_ON_STROBE || sample_strobe_i) begin
        active_d = shadow_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      idx_q <= '0;
      shadow_q <= '0;
      active_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      valid_q <= valid_d;
    end
  end
  assign done_loading = (state_q == IDLE) && !load_new_coefficients;
  assign cbram_wb_cyc_o = (state_q == READ);
  assign cbram_wb_stb_o = (state_q == READ);
  assign cbram_wb_we_o = 1'b0;
  assign cbram_wb_adr_o = BASE_ADR + BRAM_ADR_W'(idx_q);
  assign coef_o = active_q;
  assign coef_valid_o = valid_q;
endmodule

// File: tb/tb_biquad_coef_loader.sv
// tb_biquad_coef_loader: directed checks of the coefficient loader across three configurations
module tb_biquad_coef_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] ld = '0;
  logic strobe = 1'b0;
  wire [2:0] cyc, stb, we, done, valid;
  wire [10:0] adr [3];
  logic [2:0] ack;
  logic [15:0] dat [3];
  int dly [3] = '{0, 0, 0};
  logic [15:0] ofs [3] = '{16'h1000, 16'h3000, 16'h1000};
  int cnt [3] = '{0, 0, 0};
  int nrd [3] = '{0, 0, 0};
  int ndone [3] = '{0, 0, 0};
  logic [2:0] done_q = '1;
  logic [10:0] rlog [3][128];
  wire [159:0] coef0, coef1;
  wire [79:0] coef2;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  biquad_coef_loader #(.NUM_SECTIONS(2), .BASE_ADR(11'h000), .COMMIT_ON_STROBE(1'b0)) u0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .load_new_coefficients(ld[0]), .done_loading(done[0]),
    .sample_strobe_i(strobe), .cbram_wb_cyc_o(cyc[0]), .cbram_wb_stb_o(stb[0]), .cbram_wb_we_o(we[0]),
    .cbram_wb_adr_o(adr[0]), .cbram_wb_dat_i(dat[0]), .cbram_wb_ack_i(ack[0]), .coef_o(coef0),
    .coef_valid_o(valid[0]));
  biquad_coef_loader #(.NUM_SECTIONS(2), .BASE_ADR(11'h000), .COMMIT_ON_STROBE(1'b1)) u1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .load_new_coefficients(ld[1]), .done_loading(done[1]),
    .sample_strobe_i(strobe), .cbram_wb_cyc_o(cyc[1]), .cbram_wb_stb_o(stb[1]), .cbram_wb_we_o(we[1]),
    .cbram_wb_adr_o(adr[1]), .cbram_wb_dat_i(dat[1]), .cbram_wb_ack_i(ack[1]), .coef_o(coef1),
    .coef_valid_o(valid[1]));
  biquad_coef_loader #(.NUM_SECTIONS(1), .BASE_ADR(11'h7FE), .COMMIT_ON_STROBE(1'b0)) u2 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .load_new_coefficients(ld[2]), .done_loading(done[2]),
    .sample_strobe_i(strobe), .cbram_wb_cyc_o(cyc[2]), .cbram_wb_stb_o(stb[2]), .cbram_wb_we_o(we[2]),
    .cbram_wb_adr_o(adr[2]), .cbram_wb_dat_i(dat[2]), .cbram_wb_ack_i(ack[2]), .coef_o(coef2),
    .coef_valid_o(valid[2]));
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ack[i] = stb[i] && (cnt[i] == dly[i]);
      dat[i] = ofs[i] + {5'd0, adr[i]};
    end
  end
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      cnt[i] <= (stb[i] && !ack[i]) ? cnt[i] + 1 : 0;
      if (stb[i] && ack[i]) begin
        rlog[i][nrd[i] % 128] <= adr[i];
        nrd[i] <= nrd[i] + 1;
      end
      done_q[i] <= done[i];
      if (done[i] && !done_q[i]) ndone[i] <= ndone[i] + 1;
    end
  end
  function automatic logic [15:0] get_word(int i, int k);
    return i == 0 ? coef0[16*k +: 16] : i == 1 ? coef1[16*k +: 16] : coef2[16*(k%5) +: 16];
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic pulse_load(int i);
    @(negedge clk);
    ld[i] = 1'b1;
    #1 chk("done_low_in_pulse", 32'(done[i]), 0);
    @(negedge clk);
    ld[i] = 1'b0;
  endtask
  task automatic wait_reads(int i, int n0, int target);
    int t = 0;
    while (nrd[i] - n0 < target && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("read_wait", 32'(nrd[i] - n0), 32'(target));
  endtask
  typedef struct {
    int inst;
    int d;
    logic [15:0] o;
    logic [10:0] a0;
    int nw;
    int lat;
  } vec_t;
  vec_t tbl [3];
  initial begin
    int n0, lat, bad, nd0;
    logic [10:0] ea;
    tbl[0] = '{0, 0, 16'h1000, 11'h000, 10, 12};
    tbl[1] = '{0, 3, 16'h2000, 11'h000, 10, 42};
    tbl[2] = '{2, 0, 16'h1000, 11'h7FE, 5, 7};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_done", 32'(done[i]), 1);
      chk("rst_cyc_stb", {30'd0, cyc[i], stb[i]}, 0);
      chk("rst_valid", 32'(valid[i]), 0);
      chk("rst_we", 32'(we[i]), 0);
    end
    chk("rst_coef0", 32'(coef0 != '0), 0);
    for (int v = 0; v < 3; v++) begin
      dly[tbl[v].inst] = tbl[v].d;
      ofs[tbl[v].inst] = tbl[v].o;
      n0 = nrd[tbl[v].inst];
      pulse_load(tbl[v].inst);
      lat = 1;
      while (!done[tbl[v].inst] && lat < 300) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", 32'(lat), 32'(tbl[v].lat));
      chk("read_count", 32'(nrd[tbl[v].inst] - n0), 32'(tbl[v].nw));
      for (int k = 0; k < tbl[v].nw; k++) begin
        ea = tbl[v].a0 + 11'(k);
        chk("read_adr", 32'(rlog[tbl[v].inst][(n0 + k) % 128]), 32'(ea));
        chk("coef_word", 32'(get_word(tbl[v].inst, k)), 32'(tbl[v].o + {5'd0, ea}));
      end
      chk("valid", 32'(valid[tbl[v].inst]), 1);
    end
    ofs[1] = 16'h3000;
    n0 = nrd[1];
    pulse_load(1);
    wait_reads(1, n0, 9);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (coef1 != '0 || done[1] || cyc[1] || valid[1]) bad++;
    end
    chk("hold_before_strobe", 32'(bad), 0);
    chk("strobe_read_count", 32'(nrd[1] - n0), 10);
    strobe = 1'b1;
    #1 chk("done_before_commit", 32'(done[1]), 0);
    chk("coef_before_commit", 32'(get_word(1, 9)), 0);
    @(negedge clk);
    strobe = 1'b0;
    chk("done_after_commit", 32'(done[1]), 1);
    chk("valid_after_commit", 32'(valid[1]), 1);
    for (int k = 0; k < 10; k++) chk("strobe_coef", 32'(get_word(1, k)), 32'(16'h3000 + 16'(k)));
    dly[0] = 1;
    ofs[0] = 16'h6000;
    n0 = nrd[0];
    nd0 = ndone[0];
    pulse_load(0);
    wait_reads(0, n0, 4);
    ld[0] = 1'b1;
    @(negedge clk);
    ld[0] = 1'b0;
    lat = 0;
    while (!done[0] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    repeat (5) @(negedge clk);
    chk("mid_read_reads", 32'(nrd[0] - n0), 10);
    chk("mid_read_commits", 32'(ndone[0] - nd0), 1);
    chk("mid_read_coef", 32'(get_word(0, 7)), 32'h6007);
    ofs[0] = 16'h7000;
    n0 = nrd[0];
    pulse_load(0);
    wait_reads(0, n0, 4);
    chk("pre_reset_stb", 32'(stb[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_cyc_stb", {30'd0, cyc[0], stb[0]}, 0);
    chk("reset_coef", 32'(coef0 != '0), 0);
    chk("reset_valid", 32'(valid[0]), 0);
    chk("reset_done", 32'(done[0]), 1);
    n0 = nrd[0];
    repeat (5) @(negedge clk);
    chk("reset_no_reads", 32'(nrd[0] - n0), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
